// File: rtl/device_fifo.sv
`default_nettype none
// ============================================================================
// Module   : device_fifo
// Purpose  : Per-device first-word-fall-through FIFO between a bus_if device
//            port and the shared bus arbitration logic.
// Options  : DEVICE_FIFO_OVF_EN adds a sticky overflow flag port (ovf).
// Revision : 1.0 - initial release
// ============================================================================
module device_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 16,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] D_push,
  input  logic             pop,
  output logic [WIDTH-1:0] D_pop,
  output logic             pndng,
  output logic             full,
  output logic [CNTW-1:0]  count
`ifdef DEVICE_FIFO_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [CNTW-1:0]  r_count;
  logic [WIDTH-1:0] r_d_pop;

  logic             w_pndng;
  logic             w_full;
  logic             w_pop_eff;
  logic             w_push_acc;
  logic [c_AW-1:0]  w_rd_next;
  logic [CNTW-1:0]  w_count_next;

  assign w_pndng    = (r_count != '0);
  assign w_full     = (r_count == CNTW'(DEPTH));
  assign w_pop_eff  = pop && w_pndng;
  assign w_push_acc = push && (!w_full || w_pop_eff);
  assign w_rd_next  = w_pop_eff ? r_rd_ptr + c_AW'(1) : r_rd_ptr;

  always_comb begin
    w_count_next = r_count;
    unique case ({w_push_acc, w_pop_eff})
      2'b10:   w_count_next = r_count + CNTW'(1);
      2'b01:   w_count_next = r_count - CNTW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Storage is never cleared; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (reset && w_push_acc) begin
      r_mem[r_wr_ptr] <= D_push;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_d_pop  <= '0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      // The new head may be the word being written this very edge.
      if (w_count_next != '0) begin
        r_d_pop <= (w_push_acc && (r_wr_ptr == w_rd_next)) ? D_push : r_mem[w_rd_next];
      end
    end
  end

`ifdef DEVICE_FIFO_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (push && !w_push_acc) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`endif

  assign D_pop = r_d_pop;
  assign pndng = w_pndng;
  assign full  = w_full;
  assign count = r_count;

endmodule
`default_nettype wire
